// File: rtl/counter_seq_ctrl.sv
// Sequencer for a cascaded chain of counter_1b_full slices: it loads a preset, runs the
// chain, watches terminal count, and stops (one-shot) or reloads (periodic).
module counter_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int PER_W = 8
) (
  input  logic             clock_n,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             dir,
  input  logic [WIDTH-1:0] preset,
  input  logic             tc_in,
  output logic [WIDTH-1:0] data,
  output logic             load,
  output logic             hold_n,
  output logic             down_up,
  output logic             busy,
  output logic             done,
  output logic [PER_W-1:0] periods
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               mode_r;
  logic               mode_nxt;
  logic [WIDTH-1:0]   data_nxt;
  logic               down_up_nxt;
  logic [PER_W-1:0]   periods_nxt;
  logic               done_nxt;
  logic               chain_active_nxt;

  function automatic logic [PER_W-1:0] sat_inc(input logic [PER_W-1:0] v);
    logic [PER_W-1:0] r;
    if (&v) r = v;
    else    r = v + 1'b1;
    return r;
  endfunction

  always_comb begin
    state_nxt   = state;
    data_nxt    = data;
    down_up_nxt = down_up;
    mode_nxt    = mode_r;
    periods_nxt = periods;
    done_nxt    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt   = S_LOAD;
          data_nxt    = preset;
          down_up_nxt = dir;
          mode_nxt    = mode;
          periods_nxt = '0;
        end
      end
      // The chain value is stale while loading, so tc_in is not looked at here.
      S_LOAD: begin
        state_nxt = stop ? S_IDLE : S_RUN;
      end
      // stop outranks a coincident terminal count: an abort never reports completion.
      S_RUN: begin
        if (stop) begin
          state_nxt = S_IDLE;
        end else if (tc_in) begin
          done_nxt    = 1'b1;
          periods_nxt = sat_inc(periods);
          state_nxt   = mode_r ? S_LOAD : S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign chain_active_nxt = (state_nxt == S_LOAD) || (state_nxt == S_RUN);

  always_ff @(negedge clock_n or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      mode_r  <= 1'b0;
      data    <= '0;
      down_up <= 1'b0;
      periods <= '0;
      done    <= 1'b0;
      load    <= 1'b0;
      hold_n  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      mode_r  <= mode_nxt;
      data    <= data_nxt;
      down_up <= down_up_nxt;
      periods <= periods_nxt;
      done    <= done_nxt;
      load    <= (state_nxt == S_LOAD);
      hold_n  <= chain_active_nxt;
      busy    <= chain_active_nxt;
    end
  end

endmodule
